// File: rtl/memory_port_arbiter_pkg.sv
// Shared types and constants for the fetch/LSU memory port arbiter.
package memory_port_arbiter_pkg;

    localparam logic READ    = 1'b0;
    localparam logic WRITE   = 1'b1;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [3:0] FULL_WORD_MASK = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

    // A zero limit still needs a one-bit counter so the port widths stay legal.
    function automatic int unsigned timeout_cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/memory_timeout_counter.sv
// Wait-cycle counter for the memory handshake; expired_o flags the cycle whose
// increment would reach the limit. A zero limit never expires.
module memory_timeout_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH:0]   count_next;

    assign count_next = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
    assign expired_o  = enable_i && (limit_i != '0) && (count_next == {1'b0, limit_i});

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_next[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Serialises instruction fetch and LSU accesses onto the single memory port,
// round-robin on ties, with a bounded wait on mem_ready.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        fetch_request_i,
    input  logic [31:0] fetch_address_i,
    output logic        fetch_done_o,
    output logic [31:0] fetch_data_o,
    input  logic        data_request_i,
    input  logic        data_state_i,
    input  logic [31:0] data_address_i,
    input  logic [3:0]  data_frame_mask_i,
    input  logic [31:0] data_write_data_i,
    output logic        data_done_o,
    output logic [31:0] data_read_data_o,
    output logic        mem_request_o,
    output logic        mem_state_o,
    output logic [31:0] mem_address_o,
    output logic [3:0]  mem_frame_mask_o,
    output logic [31:0] mem_write_data_o,
    input  logic [31:0] mem_read_data_i,
    input  logic        mem_ready_i,
    output logic        busy_o,
    output logic        timeout_error_o
);

    localparam int unsigned      CNT_W     = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e  state_q, state_d;
    grant_e      last_grant_q, last_grant_d;
    logic        timed_out_q, timed_out_d;
    logic        mstate_q, mstate_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] fetch_data_q, fetch_data_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        cnt_clear, cnt_enable, cnt_expired;

    assign mem_request_o = (state_q == ARB_FETCH) || (state_q == ARB_DATA);
    assign cnt_clear     = (state_q == ARB_IDLE);
    assign cnt_enable    = mem_request_o && !mem_ready_i;

    memory_timeout_counter #(
        .WIDTH(CNT_W)
    ) u_timeout (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (cnt_clear),
        .enable_i (cnt_enable),
        .limit_i  (CNT_LIMIT),
        .expired_o(cnt_expired)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        timed_out_d  = timed_out_q;
        mstate_d     = mstate_q;
        addr_d       = addr_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        fetch_data_d = fetch_data_q;
        data_rdata_d = data_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (fetch_request_i || data_request_i) begin
                    if (fetch_request_i && data_request_i) begin
                        last_grant_d = (last_grant_q == GRANT_FETCH) ? GRANT_DATA : GRANT_FETCH;
                    end else begin
                        last_grant_d = data_request_i ? GRANT_DATA : GRANT_FETCH;
                    end
                    timed_out_d = 1'b0;
                    if (last_grant_d == GRANT_FETCH) begin
                        state_d  = ARB_FETCH;
                        mstate_d = READ;
                        addr_d   = fetch_address_i & 32'hFFFF_FFFC;
                        mask_d   = FULL_WORD_MASK;
                        wdata_d  = '0;
                    end else begin
                        state_d  = ARB_DATA;
                        mstate_d = data_state_i;
                        addr_d   = data_address_i;
                        mask_d   = data_frame_mask_i;
                        wdata_d  = data_write_data_i;
                    end
                end
            end
            ARB_FETCH, ARB_DATA: begin
                if (mem_ready_i) begin
                    if (state_q == ARB_FETCH) begin
                        fetch_data_d = mem_read_data_i;
                    end else if (mstate_q == READ) begin
                        data_rdata_d = mem_read_data_i;
                    end
                    state_d = ARB_DONE;
                end else if (cnt_expired) begin
                    timed_out_d = 1'b1;
                    state_d     = ARB_DONE;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_FETCH;
            timed_out_q  <= 1'b0;
            mstate_q     <= READ;
            addr_q       <= '0;
            mask_q       <= '0;
            wdata_q      <= '0;
            fetch_data_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            timed_out_q  <= timed_out_d;
            mstate_q     <= mstate_d;
            addr_q       <= addr_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
            fetch_data_q <= fetch_data_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // last_grant always names the port of the transaction in flight.
    assign busy_o           = (state_q != ARB_IDLE);
    assign fetch_done_o     = (state_q == ARB_DONE) && (last_grant_q == GRANT_FETCH);
    assign data_done_o      = (state_q == ARB_DONE) && (last_grant_q == GRANT_DATA);
    assign timeout_error_o  = (state_q == ARB_DONE) && timed_out_q;
    assign mem_state_o      = mstate_q;
    assign mem_address_o    = addr_q;
    assign mem_frame_mask_o = mask_q;
    assign mem_write_data_o = wdata_q;
    assign fetch_data_o     = fetch_data_q;
    assign data_read_data_o = data_rdata_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomised bench for memory_port_arbiter against a transaction-schedule model.
module tb_memory_port_arbiter;
    import memory_port_arbiter_pkg::*;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_request, data_request, data_state, mem_ready;
    logic [31:0] fetch_address, data_address, data_write_data, mem_read_data;
    logic [3:0]  data_frame_mask;
    logic        fetch_done, data_done, mem_request, mem_state, busy, timeout_error;
    logic [31:0] fetch_data, data_read_data, mem_address, mem_write_data;
    logic [3:0]  mem_frame_mask;

    always #5 clk = ~clk;

    memory_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .fetch_request_i  (fetch_request),
        .fetch_address_i  (fetch_address),
        .fetch_done_o     (fetch_done),
        .fetch_data_o     (fetch_data),
        .data_request_i   (data_request),
        .data_state_i     (data_state),
        .data_address_i   (data_address),
        .data_frame_mask_i(data_frame_mask),
        .data_write_data_i(data_write_data),
        .data_done_o      (data_done),
        .data_read_data_o (data_read_data),
        .mem_request_o    (mem_request),
        .mem_state_o      (mem_state),
        .mem_address_o    (mem_address),
        .mem_frame_mask_o (mem_frame_mask),
        .mem_write_data_o (mem_write_data),
        .mem_read_data_i  (mem_read_data),
        .mem_ready_i      (mem_ready),
        .busy_o           (busy),
        .timeout_error_o  (timeout_error)
    );

    // One entry per clock cycle: what the outputs must show, plus the memory response to drive.
    typedef struct {
        logic        busy, mreq, mstate, fdone, ddone, terr, rdy;
        logic [31:0] addr, wdata, fdata, drdata, rdata;
        logic [3:0]  mask;
    } cyc_t;

    cyc_t        sched[$];
    cyc_t        obs;
    bit          m_last_data;
    bit          m_state;
    bit [31:0]   m_addr, m_wdata, m_fdata, m_drdata;
    bit [3:0]    m_mask;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c = '{default: '0};
        c.mstate = m_state;
        c.addr   = m_addr;
        c.mask   = m_mask;
        c.wdata  = m_wdata;
        c.fdata  = m_fdata;
        c.drdata = m_drdata;
        return c;
    endfunction

    task automatic model_reset();
        sched.delete();
        m_last_data = 1'b0;
        m_state = 1'b0;
        m_addr = '0; m_wdata = '0; m_mask = '0;
        m_fdata = '0; m_drdata = '0;
    endtask

    // A grant schedules the whole transaction: access cycles, then one done cycle.
    task automatic plan(input bit fr, input bit dr, input bit [31:0] fa, input bit dw,
                        input bit [31:0] da, input bit [3:0] dm, input bit [31:0] dwd,
                        input int nwait, input bit [31:0] rd);
        bit   to_data, tmo;
        int   len;
        cyc_t c;
        to_data = (fr && dr) ? !m_last_data : dr;
        m_last_data = to_data;
        if (to_data) begin
            m_state = dw; m_addr = da; m_mask = dm; m_wdata = dwd;
        end else begin
            m_state = READ; m_addr = {fa[31:2], 2'b00}; m_mask = 4'hF; m_wdata = '0;
        end
        tmo = (nwait >= int'(TMO));
        len = tmo ? int'(TMO) : nwait + 1;
        for (int k = 0; k < len; k++) begin
            c = idle_cyc();
            c.busy  = 1'b1;
            c.mreq  = 1'b1;
            c.rdy   = (k == nwait);
            c.rdata = (k == nwait) ? rd : $urandom;
            sched.push_back(c);
        end
        if (!tmo) begin
            if (!to_data) m_fdata = rd;
            else if (dw == READ) m_drdata = rd;
        end
        c = idle_cyc();
        c.busy  = 1'b1;
        c.fdone = !to_data;
        c.ddone = to_data;
        c.terr  = tmo;
        sched.push_back(c);
    endtask

    task automatic step(input bit fr, input bit dr, input bit [31:0] fa, input bit dw,
                        input bit [31:0] da, input bit [3:0] dm, input bit [31:0] dwd,
                        input int nwait, input bit [31:0] rd);
        cyc_t e;
        bit   was_idle;
        @(negedge clk);
        was_idle = (sched.size() == 0);
        e = was_idle ? idle_cyc() : sched.pop_front();

        obs.busy = busy; obs.mreq = mem_request; obs.mstate = mem_state;
        obs.addr = mem_address; obs.mask = mem_frame_mask; obs.wdata = mem_write_data;
        obs.fdone = fetch_done; obs.ddone = data_done; obs.terr = timeout_error;
        obs.fdata = fetch_data; obs.drdata = data_read_data;

        chk1("busy", busy, e.busy);
        chk1("mem_request", mem_request, e.mreq);
        chk1("fetch_done", fetch_done, e.fdone);
        chk1("data_done", data_done, e.ddone);
        chk1("timeout_error", timeout_error, e.terr);
        chk("fetch_data", fetch_data, e.fdata);
        chk("data_read_data", data_read_data, e.drdata);
        if (e.mreq) begin
            chk1("mem_state", mem_state, e.mstate);
            chk("mem_address", mem_address, e.addr);
            chk("mem_frame_mask", {28'd0, mem_frame_mask}, {28'd0, e.mask});
            chk("mem_write_data", mem_write_data, e.wdata);
        end

        fetch_request   = fr;
        data_request    = dr;
        fetch_address   = fa;
        data_state      = dw;
        data_address    = da;
        data_frame_mask = dm;
        data_write_data = dwd;
        if (e.mreq) begin
            mem_ready     = e.rdy;
            mem_read_data = e.rdata;
        end else begin
            mem_ready     = 1'($urandom_range(0, 1));
            mem_read_data = $urandom;
        end
        if (was_idle && (fr || dr)) plan(fr, dr, fa, dw, da, dm, dwd, nwait, rd);
    endtask

    task automatic quiet();
        step(1'b0, 1'b0, $urandom, 1'b0, $urandom, 4'h0, $urandom, 0, $urandom);
    endtask

    task automatic drain();
        while (sched.size() != 0) quiet();
    endtask

    task automatic rstep();
        int nw;
        nw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 10)) : int'($urandom_range(0, 3));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
             $urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)), $urandom, nw, $urandom);
    endtask

    initial begin
        logic [5:0] dn;
        int         cnt;
        reset_n = 1'b0;
        fetch_request = 1'b0; data_request = 1'b0; data_state = 1'b0; mem_ready = 1'b0;
        fetch_address = '0; data_address = '0; data_write_data = '0; mem_read_data = '0;
        data_frame_mask = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_outputs", {26'd0, busy, mem_request, fetch_done, data_done, timeout_error, mem_state}, 32'd0);
        chk("reset_fetch_data", fetch_data, 32'd0);
        chk("reset_data_read_data", data_read_data, 32'd0);
        chk("reset_mem_address", mem_address, 32'd0);
        reset_n = 1'b1;

        // Both requesters held from reset: data, fetch, data.
        dn = '0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b1, 32'h0000_0100, READ, 32'h0000_2000, 4'hF, 32'h0, 0, 32'h1111_0000 + 32'(i));
            if (i == 2) dn[5:4] = {obs.fdone, obs.ddone};
            if (i == 5) dn[3:2] = {obs.fdone, obs.ddone};
            if (i == 8) dn[1:0] = {obs.fdone, obs.ddone};
        end
        chk("tie_done_order", {26'd0, dn}, {26'd0, 6'b01_10_01});
        drain();

        // Fetch only, unaligned address, zero-wait memory.
        step(1'b1, 1'b0, 32'h0000_1006, 1'b0, 32'h0, 4'h0, 32'h0, 0, 32'hDEAD_BEEF);
        quiet();
        chk("fetch_bus", {obs.mreq, obs.mstate, obs.mask}, {1'b1, READ, 4'hF});
        chk("fetch_bus_addr", obs.addr, 32'h0000_1004);
        quiet();
        chk1("fetch_done_cycle2", obs.fdone, 1'b1);
        chk("fetch_data_value", obs.fdata, 32'hDEAD_BEEF);
        drain();

        // Data write with four wait cycles.
        step(1'b0, 1'b1, 32'h0, WRITE, 32'h0000_3000, 4'b0100, 32'h0000_AB00, 4, 32'h5555_5555);
        for (int i = 0; i < 5; i++) begin
            quiet();
            chk("write_bus", {obs.mreq, obs.mstate, obs.mask}, {1'b1, WRITE, 4'b0100});
            chk("write_bus_addr", obs.addr, 32'h0000_3000);
            chk("write_bus_data", obs.wdata, 32'h0000_AB00);
        end
        quiet();
        chk1("write_done", obs.ddone, 1'b1);
        chk("write_keeps_read_data", obs.drdata, 32'h1111_0006);
        quiet();
        chk1("write_done_once", obs.ddone, 1'b0);
        drain();

        // Memory never answers: timeout after TMO request cycles.
        step(1'b1, 1'b0, 32'h0000_4000, 1'b0, 32'h0, 4'h0, 32'h0, 100, 32'h1234_5678);
        cnt = 0;
        for (int i = 0; i < int'(TMO); i++) begin
            quiet();
            cnt += int'(obs.mreq);
        end
        chk("timeout_request_cycles", 32'(cnt), 32'(TMO));
        quiet();
        chk("timeout_done", {29'd0, obs.fdone, obs.terr, obs.mreq}, 32'b110);
        chk("timeout_fetch_data", obs.fdata, 32'hDEAD_BEEF);
        quiet();
        chk1("timeout_then_idle", obs.busy, 1'b0);
        drain();

        // Asynchronous reset during a data wait.
        step(1'b0, 1'b1, 32'h0, READ, 32'h0000_5000, 4'hF, 32'h0, 6, 32'h9999_9999);
        repeat (3) quiet();
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", {27'd0, mem_request, busy, fetch_done, data_done, timeout_error}, 32'd0);
        chk("async_reset_read_data", data_read_data, 32'd0);
        model_reset();
        fetch_request = 1'b0;
        data_request = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 32'h0000_6000, 1'b0, 32'h0, 4'h0, 32'h0, 1, 32'h0000_0077);
        quiet();
        chk("post_reset_fetch_bus", {28'd0, obs.mreq, obs.mstate, obs.busy, obs.ddone}, {28'd0, 1'b1, READ, 1'b1, 1'b0});
        chk("post_reset_fetch_addr", obs.addr, 32'h0000_6000);
        quiet();
        quiet();
        chk1("post_reset_fetch_done", obs.fdone, 1'b1);
        drain();

        // Request dropped mid-access: the access still completes.
        step(1'b0, 1'b1, 32'h0, READ, 32'h0000_7000, 4'hF, 32'h0, 3, 32'h8888_0000);
        step(1'b0, 1'b1, 32'h0, READ, 32'h0000_7000, 4'hF, 32'h0, 3, 32'h8888_0000);
        repeat (3) quiet();
        quiet();
        chk1("drop_done", obs.ddone, 1'b1);
        chk("drop_read_data", obs.drdata, 32'h8888_0000);
        cnt = 0;
        repeat (3) begin
            quiet();
            cnt += int'(obs.busy);
        end
        chk("drop_no_regrant", 32'(cnt), 32'd0);
        drain();

        repeat (3000) rstep();
        drain();
        quiet();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares the core's single external memory port between the instruction-fetch path and the load/store unit's memory interface. Requests are serialised through a four-state FSM, with round-robin tie-break and a bounded wait on the memory handshake. It sits between the fetch stage/LSU and the memory bus. Word alignment, frame masks and write data arrive already formed by the LSU.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles to wait for mem_ready; 0 disables the timeout.
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_request  in  1  fetch wants a word; level, sampled only in IDLE.
- fetch_address  in  32  fetch byte address; bits [1:0] are ignored.
- fetch_done  out  1  one-cycle completion pulse for the fetch port.
- fetch_data  out  32  last fetched word; held until the next fetch completes.
- data_request  in  1  LSU memory enable; level, sampled only in IDLE.
- data_state  in  1  `READ` / `WRITE` from Defines.v.
- data_address  in  32  word-aligned address from the LSU.
- data_frame_mask  in  4  byte-lane mask from the LSU.
- data_write_data  in  32  lane-positioned store data.
- data_done  out  1  one-cycle completion pulse for the data port.
- data_read_data  out  32  last loaded word; updated only by data reads.
- mem_request  out  1  bus request; held until mem_ready or timeout.
- mem_state  out  1  `READ` / `WRITE`.
- mem_address  out  32  word-aligned bus address.
- mem_frame_mask  out  4  bus byte-lane mask.
- mem_write_data  out  32  bus write data.
- mem_read_data  in  32  bus read data; valid when mem_ready is high.
- mem_ready  in  1  memory completes the current access in this cycle.
- busy  out  1  high in every state except IDLE.
- timeout_error  out  1  one-cycle pulse, coincident with done, on timeout.

## Operation
- FSM states: IDLE, FETCH, DATA, DONE.
- IDLE, single request: grant that port.
- IDLE, both requests: grant the port not granted last; `last_grant` resets to FETCH, so data wins the first tie.
- On grant: latch address, state, mask and write data into the bus registers.
  - Fetch grant forces `READ`, mask 4'b1111 and {fetch_address[31:2], 2'b00}.
  - Write data is 0 for fetches.
  - Update `last_grant` and clear the timeout counter.
- FETCH/DATA: mem_request is high.
  - mem_ready high: capture mem_read_data into fetch_data, or into data_read_data for a data `READ` (writes capture nothing). Drop mem_request and go to DONE.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES (nonzero), drop mem_request, set the error flag and go to DONE. Nothing is captured.
- DONE: pulse the granted port's done (and timeout_error if flagged), then go to IDLE.
- A request deasserted during FETCH/DATA does not abort the access; done still pulses.
- A request still high in the IDLE cycle after DONE starts a new transaction.
- mem_address, mem_frame_mask, mem_state and mem_write_data are stable for the whole FETCH/DATA interval.

## Timing
- Reset (async assert): state IDLE, `last_grant` FETCH, counter 0. Every output is 0, including fetch_data and data_read_data.
- Reset asserted mid-transaction drops mem_request immediately; no done pulse is issued.
- Cycle 0: IDLE samples the request.
- Cycle 1: FETCH/DATA with mem_request high.
  - mem_ready in cycle 1 → DONE in cycle 2, done high for cycle 2 only, captured data visible from cycle 2.
- Minimum 3 cycles from request sample to the next IDLE sample.
- Each extra wait cycle adds 1 cycle.
- With timeout, DONE follows TIMEOUT_CYCLES wait cycles.
- The requester must drop its request during the done cycle to avoid a re-grant.
- mem_ready outside FETCH/DATA is ignored.

## Structure
- Defines.v gains `ARB_IDLE`, `ARB_FETCH`, `ARB_DATA` and `ARB_DONE` (2-bit), plus `GRANT_FETCH` / `GRANT_DATA`.
- Existing `READ`, `WRITE`, `ENABLE` and `DISABLE` are reused.
- One natural sub-module, `memory_timeout_counter`: clear, enable and limit inputs; expired output; width $clog2(TIMEOUT_CYCLES+1).
- The LSU's bidirectional data bus is resolved outside this block; separate in/out buses are used here.

## Test plan
- Fetch only, addr 0x0000_1006, mem_ready in cycle 1 with 0xDEAD_BEEF:
  - mem_address 0x0000_1004, mask 1111, `READ`.
  - fetch_done in cycle 2, fetch_data 0xDEAD_BEEF.
- Simultaneous requests after reset, both held:
  - Grant order DATA, FETCH, DATA.
  - done pulses alternate, 3 cycles apart with zero-wait memory.
- Data `WRITE`, mask 0100, data 0x0000_AB00, mem_ready after 4 wait cycles:
  - Bus fields stable for all 5 request cycles.
  - data_done once; data_read_data unchanged.
- TIMEOUT_CYCLES=8, mem_ready never asserted:
  - mem_request high for 8 cycles, then timeout_error and fetch_done pulse together.
  - fetch_data unchanged; busy low on the following cycle.
- Reset pulled low during a DATA wait:
  - mem_request, busy and done go 0 immediately.
  - After release, a pending fetch is granted first (last_grant is FETCH, no tie).
- data_request dropped in cycle 2 of a 3-wait access:
  - The access still completes and data_done pulses.
  - No new grant while the request stays low.
